dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the CPU load/store port. It accepts one load or store request through a valid/ready handshake and inserts a configurable number of wait states. It performs byte/half/word lane steering with RV32I sign or zero extension, then returns a response with data and an error flag through a second valid/ready handshake. It replaces the CPU's inline data array so the core can be moved to a multi-cycle or stalled memory model.

Parameters:
ADDR_W, 10, word-address width; storage depth = 2**ADDR_W 32-bit words
WAIT_CYCLES, 1, wait states between request acceptance and memory access (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Clock and reset: clk; rst synchronous, active-low.
- While rst=0, on each clock edge:
  - state goes to IDLE, wait counter to 0;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, latch we/funct3/addr/wdata. Go to WAIT if WAIT_CYCLES>0, otherwise perform the access this edge and go to RESP.
  - WAIT: req_ready=0. Counter runs from WAIT_CYCLES-1 down to 0. On the edge where it reaches 0, perform the access and go to RESP.
  - RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_valid&rsp_ready. On that handshake go to IDLE and clear rsp_rdata/rsp_err.
- Latency: with acceptance at edge N, rsp_valid is high from edge N+WAIT_CYCLES+1.
  - With immediate rsp_ready, minimum turnaround is WAIT_CYCLES+2 cycles per request.
- Access rules:
  - Word index = addr[ADDR_W+1:2]; lane = addr[1:0].
  - Store funct3 000 (sb): write wdata[7:0] to byte lane addr[1:0]. Other bytes unchanged.
  - Store funct3 001 (sh): write wdata[15:0] to half lane addr[1]. Other half unchanged.
  - Store funct3 010 (sw): write the full word.
  - Load funct3 000 (lb) and 001 (lh): selected byte/half, sign-extended to 32 bits.
  - Load funct3 010 (lw): full word.
  - Load funct3 100 (lbu) and 101 (lhu): selected byte/half, zero-extended.
- Error conditions (rsp_err=1, no storage write, rsp_rdata=0):
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:ADDR_W+2]≠0;
  - store funct3 not in {000,001,010};
  - load funct3 in {011,110,111}.
- A store response carries rsp_rdata=0 and rsp_err=0 on success.
- A write commits only on the access edge. A reset asserted in WAIT abandons the request with no write. A reset in RESP drops the pending response.
- Request inputs are ignored outside IDLE; they are not latched.
- rsp_ready held high with no response pending has no effect.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state enum {IDLE, WAIT, RESP};
  - function is_legal(we, funct3, addr_lo).
- Sub-module dmem_lane_align (combinational):
  - store path: 4-bit byte-enable plus lane-shifted wdata;
  - load path: lane-selected, extended rdata.
- Storage array and FSM stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=1; sw 0xDEADBEEF @0x10, then lw @0x10 -> each rsp_valid 2 cycles after accept; lw returns 0xDEADBEEF, rsp_err=0.
- After the sw: sb 0x7F @0x11, then lb @0x11 and lbu @0x13 -> word = 0xDEAD7FEF; lb=0x0000007F; lbu=0x000000DE.
- sh 0x8001 @0x12, then lh @0x12 and lhu @0x12 -> lh=0xFFFF8001; lhu=0x00008001; lower half 0x7FEF unchanged.
- lw @0x12, sh @0x11, and lw @0x00001000 with ADDR_W=10 -> rsp_err=1, rsp_rdata=0; word @0x10 unchanged.
- Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid, rsp_rdata, rsp_err stable; req_ready=0; a new req_valid is not accepted until the handshake completes.
- sw @0x20 accepted with WAIT_CYCLES=3, rst=0 pulsed during WAIT -> no response; a later lw @0x20 returns the prior value. All outputs 0 during reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RV32I load/store funct3 encodings
//   - responder FSM state type
//   - is_legal(): funct3 / alignment legality of an access
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Legality ignoring the address range: stores only know b/h/w, loads
   // additionally know the unsigned variants; halves need even addresses,
   // words need 4-byte alignment.
   function automatic logic is_legal(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_BU:   ok = !we;
         F3_H:    ok = !addr_lo[0];
         F3_HU:   ok = !we && !addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for RV32I loads/stores.
//   funct3     in  : access size / signedness
//   addr_lo    in  : byte lane within the word
//   wdata      in  : right-aligned store data
//   rword      in  : full 32-bit word read from storage
//   wbe        out : per-byte write enable for stores
//   wdata_lane out : store data replicated so every enabled lane sees its byte
//   rdata_ext  out : selected byte/half/word, sign- or zero-extended
// Legality is not checked here; the caller gates wbe and rdata_ext.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wbe,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   // Move the addressed lane down to bit 0 so byte/half selection is fixed.
   logic [31:0] rword_sh;
   assign rword_sh = rword >> {addr_lo, 3'b000};

   always_comb begin
      // NOTE: every output gets a default first so no path through the case leaves a latch.
      wbe        = 4'b0000;
      wdata_lane = 32'h0;
      rdata_ext  = 32'h0;
      case (funct3)
         F3_B, F3_BU: begin
            wbe        = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = (funct3 == F3_B) ? {{24{rword_sh[7]}}, rword_sh[7:0]}
                                          : {24'h0, rword_sh[7:0]};
         end
         F3_H, F3_HU: begin
            wbe        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = (funct3 == F3_H) ? {{16{rword_sh[15]}}, rword_sh[15:0]}
                                          : {16'h0, rword_sh[15:0]};
         end
         F3_W: begin
            wbe        = 4'b1111;
            wdata_lane = wdata;
            rdata_ext  = rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU load/store port.
// One request is accepted on req_valid&req_ready, held for WAIT_CYCLES wait
// states, then the storage access is performed and the result is returned
// on a registered rsp_valid/rsp_ready handshake.
//   clk, rst            : clock; synchronous active-low reset
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I load/store funct3
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data; 0 for stores and errors
//   rsp_err             : misaligned, out-of-range or illegal funct3
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem [DEPTH];

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic        accept;
   logic        access_now;
   logic        acc_we;
   logic [2:0]  acc_funct3;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_ok;
   logic [ADDR_W-1:0] acc_idx;
   logic [31:0] rword;
   logic [3:0]  wbe;
   logic [31:0] wdata_lane;
   logic [31:0] rdata_ext;

   assign accept = (state_q == IDLE) && req_valid && req_ready_q;

   // With zero wait states the access happens on the acceptance edge, so it
   // must use the live request inputs rather than the latched copy.
   assign acc_we     = (state_q == IDLE) ? req_we     : we_q;
   assign acc_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
   assign acc_addr   = (state_q == IDLE) ? req_addr   : addr_q;
   assign acc_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;

   assign access_now = ((WAIT_CYCLES == 0) && accept) ||
                       ((state_q == WAIT) && (cnt_q == 4'd0));

   assign acc_idx = acc_addr[ADDR_W+1:2];
   assign acc_ok  = (acc_addr[31:ADDR_W+2] == '0) &&
                    is_legal(acc_we, acc_funct3, acc_addr[1:0]);
   assign rword   = mem[acc_idx];

   dmem_lane_align u_align (
      .funct3     (acc_funct3),
      .addr_lo    (acc_addr[1:0]),
      .wdata      (acc_wdata),
      .rword      (rword),
      .wbe        (wbe),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext)
   );

   // NOTE: storage has no reset; only the control and output flops are cleared.
   always_ff @(posedge clk) begin
      if (rst && access_now && acc_we && acc_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (wbe[i]) mem[acc_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (access_now) begin
         rsp_rdata_d = (acc_ok && !acc_we) ? rdata_ext : 32'h0;
         rsp_err_d   = !acc_ok;
      end

      // Handshake outputs are registered copies of the next state.
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Instance 0 uses WAIT_CYCLES=1, instance 1 uses WAIT_CYCLES=3. Expected
// values come from a word-array model that applies the RV32I load/store
// rules with plain arithmetic.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_rdata  [2];
   logic        rsp_err    [2];

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mdl [2][1024];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   function automatic int wc(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour: returns the response and updates the word array.
   function automatic void model(input int u, input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er);
      int          lane = int'(addr % 4);
      int          idx  = int'((addr / 4) % 1024);
      int          sh   = 8 * lane;
      logic [31:0] w    = mdl[u][idx];
      logic [31:0] b, h;
      er = ((addr >> 12) != 0)
           || ((f3 == 3'd1 || f3 == 3'd5) && (lane % 2 == 1))
           || (f3 == 3'd2 && lane != 0)
           || (we && f3 > 3'd2)
           || (!we && (f3 == 3'd3 || f3 >= 3'd6));
      rd = 32'h0;
      if (!er) begin
         if (we) begin
            if (f3 == 3'd0)      w = (w & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh);
            else if (f3 == 3'd1) w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            else                 w = wd;
            mdl[u][idx] = w;
         end else begin
            b = (w >> sh) & 32'hFF;
            h = (w >> sh) & 32'hFFFF;
            case (f3)
               3'd0:    rd = (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
               3'd1:    rd = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
               3'd4:    rd = b;
               3'd5:    rd = h;
               default: rd = w;
            endcase
         end
      end
   endfunction

   // One full transaction; starts and ends on a falling edge.
   task automatic txn(input int u, input bit we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, input string tag, output logic [31:0] got);
      logic [31:0] exp_rd;
      logic        exp_er;
      int          t;
      int          lat;
      logic [31:0] first_rd;
      logic        first_er;
      model(u, we, f3, addr, wd, exp_rd, exp_er);
      t = 0;
      while (req_ready[u] !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_ready"}, 32'(req_ready[u]), 32'd1);
      req_valid[u]  = 1'b1;
      req_we[u]     = we;
      req_funct3[u] = f3;
      req_addr[u]   = addr;
      req_wdata[u]  = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid[u] = 1'b0;
      lat = 0;
      while (rsp_valid[u] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      // rsp_valid is first sampled by edge N+WAIT_CYCLES+1 after acceptance at N.
      check({tag, "_lat"}, 32'(lat), 32'(wc(u)));
      check({tag, "_rdata"}, rsp_rdata[u], exp_rd);
      check({tag, "_err"}, 32'(rsp_err[u]), 32'(exp_er));
      got      = rsp_rdata[u];
      first_rd = rsp_rdata[u];
      first_er = rsp_err[u];
      for (int i = 0; i < hold; i++) begin
         req_valid[u]  = 1'b1;
         req_we[u]     = 1'b1;
         req_funct3[u] = 3'b010;
         req_addr[u]   = 32'h0;
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(rsp_valid[u]), 32'd1);
         check({tag, "_hold_rdata"}, rsp_rdata[u], first_rd);
         check({tag, "_hold_err"}, 32'(rsp_err[u]), 32'(first_er));
         check({tag, "_hold_ready"}, 32'(req_ready[u]), 32'd0);
      end
      req_valid[u] = 1'b0;
      rsp_ready[u] = 1'b1;
      @(negedge clk);
      rsp_ready[u] = 1'b0;
      check({tag, "_post_valid"}, 32'(rsp_valid[u]), 32'd0);
      check({tag, "_post_clr"}, rsp_rdata[u] | 32'(rsp_err[u]), 32'd0);
      check({tag, "_post_ready"}, 32'(req_ready[u]), 32'd1);
   endtask

   task automatic check_zero(input int u, input string tag);
      check({tag, "_zero"},
            {req_ready[u], rsp_valid[u], rsp_err[u], 29'h0} | rsp_rdata[u], 32'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      bit          seen;
      int          u;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;

      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'b0;
         req_addr[i] = 32'h0; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_zero(0, "reset0");
      check_zero(1, "reset1");
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      @(negedge clk);

      // Directed sequence on the single-wait-state instance.
      txn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10", got);
      txn(0, 0, 3'b010, 32'h10, 32'h0, 0, "lw10", got);
      check("lw10_plan", got, 32'hDEADBEEF);
      txn(0, 1, 3'b000, 32'h11, 32'h7F, 0, "sb11", got);
      txn(0, 0, 3'b010, 32'h10, 32'h0, 0, "lw10b", got);
      check("sb_word_plan", got, 32'hDEAD7FEF);
      txn(0, 0, 3'b000, 32'h11, 32'h0, 0, "lb11", got);
      check("lb_plan", got, 32'h0000007F);
      txn(0, 0, 3'b100, 32'h13, 32'h0, 0, "lbu13", got);
      check("lbu_plan", got, 32'h000000DE);
      txn(0, 1, 3'b001, 32'h12, 32'h8001, 0, "sh12", got);
      txn(0, 0, 3'b001, 32'h12, 32'h0, 0, "lh12", got);
      check("lh_plan", got, 32'hFFFF8001);
      txn(0, 0, 3'b101, 32'h12, 32'h0, 0, "lhu12", got);
      check("lhu_plan", got, 32'h00008001);
      txn(0, 0, 3'b010, 32'h10, 32'h0, 0, "lw10c", got);
      check("sh_word_plan", got, 32'h80017FEF);

      // Error cases: misaligned, out of range, illegal funct3.
      txn(0, 0, 3'b010, 32'h12, 32'h0, 0, "err_lw12", got);
      txn(0, 1, 3'b001, 32'h11, 32'h1234, 0, "err_sh11", got);
      txn(0, 0, 3'b010, 32'h1000, 32'h0, 0, "err_range", got);
      txn(0, 1, 3'b011, 32'h10, 32'h55555555, 0, "err_st_f3", got);
      txn(0, 1, 3'b100, 32'h10, 32'h66666666, 0, "err_st_bu", got);
      txn(0, 0, 3'b110, 32'h10, 32'h0, 0, "err_ld_f3", got);
      txn(0, 0, 3'b010, 32'h10, 32'h0, 0, "lw10_after_err", got);
      check("err_nowrite_plan", got, 32'h80017FEF);

      // Backpressure: response held for five cycles.
      txn(0, 0, 3'b010, 32'h10, 32'h0, 5, "hold", got);

      // rsp_ready with nothing pending has no effect.
      rsp_ready[0] = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid[0] !== 1'b0) seen = 1'b1;
      end
      rsp_ready[0] = 1'b0;
      check("idle_rsp_ready", 32'(seen), 32'd0);
      check("idle_req_ready", 32'(req_ready[0]), 32'd1);

      // Reset during WAIT abandons a store (three-wait-state instance).
      txn(1, 1, 3'b010, 32'h20, 32'h11223344, 0, "sw20", got);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
      req_addr[1] = 32'h20; req_wdata[1] = 32'hAABBCCDD;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      check_zero(1, "rst_wait_a");
      @(negedge clk);
      check_zero(1, "rst_wait_b");
      rst[1] = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid[1] !== 1'b0) seen = 1'b1;
      end
      check("rst_no_rsp", 32'(seen), 32'd0);
      txn(1, 0, 3'b010, 32'h20, 32'h0, 0, "lw20", got);
      check("rst_nowrite_plan", got, 32'h11223344);

      // Randomized traffic over a small window of initialized words.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            txn(k, 1, 3'b010, 32'(i * 4), $urandom, 0, "init", got);
         end
      end
      for (int n = 0; n < 200; n++) begin
         u    = int'($urandom_range(0, 1));
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         addr = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
         txn(u, we, f3, addr, $urandom, int'($urandom_range(0, 2)), "rand", got);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
